// File: rtl/memory_access_stage_if.sv
// rtl/memory_access_stage_if.sv - data-memory req/ack bus between the MEM stage and data memory
interface memory_access_stage_if #(
    parameter int XLEN = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_wstrb;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - MEM pipeline stage: load/store over req/ack bus, feeds MEM/WB
module memory_access_stage #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mem_result_src,
    input  logic                  mem_mem_write,
    input  logic                  mem_reg_write,
    input  logic [2:0]            mem_funct3,
    input  logic [4:0]            mem_rd,
    input  logic [XLEN-1:0]       mem_alu_result,
    input  logic [XLEN-1:0]       mem_store_data,
    memory_access_stage_if.master dmem,
    output logic                  stall_mem,
    output logic                  misaligned,
    output logic                  bus_error,
    output logic                  wb_reg_write,
    output logic [1:0]            wb_result_src,
    output logic [4:0]            wb_rd,
    output logic [XLEN-1:0]       wb_alu_result,
    output logic [XLEN-1:0]       wb_read_data
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic [XLEN-1:0] rd_latch;

    logic            is_load;
    logic            is_store;
    logic            mem_op;
    logic            funct3_ok;
    logic            align_ok;
    logic            bad_op;
    logic            good_op;
    logic            wb_pass;
    logic [1:0]      off;
    logic [3:0]      st_wstrb;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] rd_shift;
    logic [XLEN-1:0] load_ext;

    // Decode the operation; a store wins when the load and store controls are both set.
    always_comb begin
        is_store = mem_mem_write;
        is_load  = (mem_result_src == 2'b01) && !mem_mem_write;
        mem_op   = is_store || is_load;
        off      = mem_alu_result[1:0];
        if (is_store) begin
            funct3_ok = (mem_funct3 == 3'b000) || (mem_funct3 == 3'b001) || (mem_funct3 == 3'b010);
        end else begin
            funct3_ok = (mem_funct3 == 3'b000) || (mem_funct3 == 3'b001) || (mem_funct3 == 3'b010)
                     || (mem_funct3 == 3'b100) || (mem_funct3 == 3'b101);
        end
        case (mem_funct3[1:0])
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = !off[0];
            2'b10:   align_ok = (off == 2'b00);
            default: align_ok = 1'b0;
        endcase
        bad_op  = mem_op && !(funct3_ok && align_ok);
        good_op = mem_op && !bad_op;
        // Gated by reset so every output reads 0 while reset is held, whatever the inputs.
        misaligned = reset && (state == IDLE) && bad_op;
        stall_mem  = reset && (((state == IDLE) && good_op) || (state == BUSY));
        wb_pass    = ((state == IDLE) && !mem_op) || (state == DONE);
    end

    // Store lane steering and load extraction/extension from the addressed byte lane.
    always_comb begin
        case (mem_funct3[1:0])
            2'b00: begin
                st_wstrb = 4'b0001 << off;
                st_wdata = {4{mem_store_data[7:0]}};
            end
            2'b01: begin
                st_wstrb = 4'b0011 << off;
                st_wdata = {2{mem_store_data[15:0]}};
            end
            default: begin
                st_wstrb = 4'hF;
                st_wdata = mem_store_data;
            end
        endcase
        rd_shift = dmem.dmem_rdata >> {off, 3'b000};
        case (mem_funct3)
            3'b000:  load_ext = {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_ext = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_ext = dmem.dmem_rdata;
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
            default: load_ext = '0;
        endcase
    end

    // Bus FSM: launch the access from IDLE, hold it in BUSY until ack or timeout, release in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            rd_latch        <= '0;
            bus_error       <= 1'b0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            dmem.dmem_wstrb <= 4'b0000;
        end else begin
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (good_op) begin
                        state           <= BUSY;
                        wait_cnt        <= CW'(1);
                        dmem.dmem_req   <= 1'b1;
                        dmem.dmem_we    <= is_store;
                        dmem.dmem_addr  <= {mem_alu_result[XLEN-1:2], 2'b00};
                        dmem.dmem_wdata <= is_store ? st_wdata : '0;
                        dmem.dmem_wstrb <= is_store ? st_wstrb : 4'b0000;
                    end
                end
                BUSY: begin
                    if (dmem.dmem_ack) begin
                        dmem.dmem_req <= 1'b0;
                        rd_latch      <= is_load ? load_ext : '0;
                        state         <= DONE;
                    end else if (wait_cnt == CW'(MAX_WAIT)) begin
                        dmem.dmem_req <= 1'b0;
                        bus_error     <= 1'b1;
                        rd_latch      <= '0;
                        state         <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // MEM/WB register: pass the op through when not stalled, otherwise insert a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_reg_write  <= 1'b0;
            wb_result_src <= 2'b00;
            wb_rd         <= '0;
            wb_alu_result <= '0;
            wb_read_data  <= '0;
        end else if (wb_pass) begin
            wb_reg_write  <= mem_reg_write;
            wb_result_src <= mem_result_src;
            wb_rd         <= mem_rd;
            wb_alu_result <= mem_alu_result;
            wb_read_data  <= (state == DONE) ? rd_latch : '0;
        end else begin
            wb_reg_write  <= 1'b0;
            wb_result_src <= 2'b00;
            wb_rd         <= '0;
            wb_alu_result <= '0;
            wb_read_data  <= '0;
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - directed vector bench for memory_access_stage
module tb_memory_access_stage;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_result_src;
    logic        mem_mem_write;
    logic        mem_reg_write;
    logic [2:0]  mem_funct3;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_store_data;
    logic        stall_mem;
    logic        misaligned;
    logic        bus_error;
    logic        wb_reg_write;
    logic [1:0]  wb_result_src;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_read_data;

    int n_vec  = 0;
    int n_fail = 0;

    memory_access_stage_if #(.XLEN(32)) dmem_bus ();

    memory_access_stage #(.XLEN(32), .MAX_WAIT(15)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_result_src (mem_result_src),
        .mem_mem_write  (mem_mem_write),
        .mem_reg_write  (mem_reg_write),
        .mem_funct3     (mem_funct3),
        .mem_rd         (mem_rd),
        .mem_alu_result (mem_alu_result),
        .mem_store_data (mem_store_data),
        .dmem           (dmem_bus),
        .stall_mem      (stall_mem),
        .misaligned     (misaligned),
        .bus_error      (bus_error),
        .wb_reg_write   (wb_reg_write),
        .wb_result_src  (wb_result_src),
        .wb_rd          (wb_rd),
        .wb_alu_result  (wb_alu_result),
        .wb_read_data   (wb_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rs;
        logic        mw;
        logic        rw;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_mis;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic [31:0] e_rdat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] rs, input logic mw, input logic rw,
                                input logic [2:0] f3, input logic [4:0] rd,
                                input logic [31:0] alu, input logic [31:0] sd,
                                input logic [31:0] rdata, input logic e_stall,
                                input logic e_mis, input logic e_we, input logic [31:0] e_addr,
                                input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                                input logic [31:0] e_rdat);
        vec_t v;
        v.rs = rs; v.mw = mw; v.rw = rw; v.f3 = f3; v.rd = rd;
        v.alu = alu; v.sd = sd; v.rdata = rdata;
        v.e_stall = e_stall; v.e_mis = e_mis; v.e_we = e_we;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wstrb = e_wstrb; v.e_rdat = e_rdat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] rs, input logic mw, input logic rw, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd);
        mem_result_src = rs;
        mem_mem_write  = mw;
        mem_reg_write  = rw;
        mem_funct3     = f3;
        mem_rd         = rd;
        mem_alu_result = alu;
        mem_store_data = sd;
    endtask

    task automatic drive_nop();
        drive(2'b00, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
    endtask

    // Present one op at a falling edge, answer the bus in the first BUSY cycle, check MEM/WB.
    task automatic apply(input vec_t v);
        logic bubble;
        bubble = v.e_mis;
        drive(v.rs, v.mw, v.rw, v.f3, v.rd, v.alu, v.sd);
        #1;
        check("stall_present", 32'(stall_mem), 32'(v.e_stall));
        check("misaligned", 32'(misaligned), 32'(v.e_mis));
        if (v.e_stall) begin
            @(negedge clk);
            check("busy_req", 32'(dmem_bus.dmem_req), 32'd1);
            check("busy_stall", 32'(stall_mem), 32'd1);
            check("busy_we", 32'(dmem_bus.dmem_we), 32'(v.e_we));
            check("busy_addr", dmem_bus.dmem_addr, v.e_addr);
            if (v.e_we) begin
                check("busy_wdata", dmem_bus.dmem_wdata, v.e_wdata);
                check("busy_wstrb", 32'(dmem_bus.dmem_wstrb), 32'(v.e_wstrb));
            end
            dmem_bus.dmem_ack   = 1'b1;
            dmem_bus.dmem_rdata = v.rdata;
            @(negedge clk);
            dmem_bus.dmem_ack   = 1'b0;
            dmem_bus.dmem_rdata = 32'h0;
            check("done_stall", 32'(stall_mem), 32'd0);
            check("done_req", 32'(dmem_bus.dmem_req), 32'd0);
            check("done_bus_error", 32'(bus_error), 32'd0);
        end
        @(negedge clk);
        check("wb_reg_write", 32'(wb_reg_write), bubble ? 32'd0 : 32'(v.rw));
        check("wb_rd", 32'(wb_rd), bubble ? 32'd0 : 32'(v.rd));
        check("wb_result_src", 32'(wb_result_src), bubble ? 32'd0 : 32'(v.rs));
        check("wb_alu_result", wb_alu_result, bubble ? 32'd0 : v.alu);
        check("wb_read_data", wb_read_data, v.e_rdat);
        check("req_after", 32'(dmem_bus.dmem_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        //      rs     mw    rw    f3      rd     alu          sd            rdata         st mis we addr         wdata         wstrb    rdat
        tbl.push_back(mk(2'b00, 1'b0, 1'b1, 3'b000, 5'd5,  32'h10,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0,    32'h0));
        tbl.push_back(mk(2'b01, 1'b0, 1'b1, 3'b000, 5'd7,  32'h103, 32'h0,        32'h80FFFFFF, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0,        4'h0,    32'hFFFFFF80));
        tbl.push_back(mk(2'b00, 1'b1, 1'b0, 3'b001, 5'd0,  32'h22,  32'h1234ABCD, 32'h0,        1'b1, 1'b0, 1'b1, 32'h20,  32'hABCDABCD, 4'b1100, 32'h0));
        tbl.push_back(mk(2'b01, 1'b0, 1'b1, 3'b010, 5'd4,  32'h6,   32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0,    32'h0));
        tbl.push_back(mk(2'b01, 1'b0, 1'b1, 3'b100, 5'd9,  32'h101, 32'h0,        32'h1234F6A5, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0,        4'h0,    32'h000000F6));
        tbl.push_back(mk(2'b01, 1'b0, 1'b1, 3'b001, 5'd10, 32'h102, 32'h0,        32'h80017FFF, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0,        4'h0,    32'hFFFF8001));
        tbl.push_back(mk(2'b01, 1'b0, 1'b1, 3'b101, 5'd11, 32'h100, 32'h0,        32'h8001F00D, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0,        4'h0,    32'h0000F00D));
        tbl.push_back(mk(2'b01, 1'b0, 1'b1, 3'b010, 5'd12, 32'h204, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h204, 32'h0,        4'h0,    32'hDEADBEEF));
        tbl.push_back(mk(2'b00, 1'b1, 1'b0, 3'b000, 5'd0,  32'h13,  32'h000000A5, 32'h0,        1'b1, 1'b0, 1'b1, 32'h10,  32'hA5A5A5A5, 4'b1000, 32'h0));
        tbl.push_back(mk(2'b00, 1'b1, 1'b0, 3'b010, 5'd0,  32'h40,  32'hCAFEF00D, 32'h55555555, 1'b1, 1'b0, 1'b1, 32'h40,  32'hCAFEF00D, 4'hF,    32'h0));
        tbl.push_back(mk(2'b00, 1'b1, 1'b0, 3'b001, 5'd0,  32'h21,  32'h1,        32'h0,        1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0,    32'h0));
        tbl.push_back(mk(2'b01, 1'b0, 1'b1, 3'b011, 5'd6,  32'h0,   32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0,    32'h0));
        tbl.push_back(mk(2'b00, 1'b1, 1'b0, 3'b100, 5'd0,  32'h8,   32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        4'h0,    32'h0));
        tbl.push_back(mk(2'b01, 1'b1, 1'b1, 3'b010, 5'd13, 32'h8,   32'h11223344, 32'h99999999, 1'b1, 1'b0, 1'b1, 32'h8,   32'h11223344, 4'hF,    32'h0));
        tbl.push_back(mk(2'b10, 1'b0, 1'b1, 3'b000, 5'd1,  32'h44,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0,    32'h0));
        tbl.push_back(mk(2'b01, 1'b0, 1'b1, 3'b000, 5'd14, 32'h200, 32'h0,        32'hFFFFFF7F, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0,        4'h0,    32'h0000007F));

        reset = 1'b0;
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        drive_nop();
        repeat (2) @(negedge clk);
        check("rst_req", 32'(dmem_bus.dmem_req), 32'd0);
        check("rst_we", 32'(dmem_bus.dmem_we), 32'd0);
        check("rst_addr", dmem_bus.dmem_addr, 32'd0);
        check("rst_wstrb", 32'(dmem_bus.dmem_wstrb), 32'd0);
        check("rst_stall", 32'(stall_mem), 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        check("rst_bus_error", 32'(bus_error), 32'd0);
        check("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_wb_read_data", wb_read_data, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Timeout: no ack ever, expect exactly 15 BUSY cycles then a one-cycle bus_error.
        drive(2'b01, 1'b0, 1'b1, 3'b010, 5'd3, 32'h30, 32'h0);
        busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!dmem_bus.dmem_req) break;
            busy++;
        end
        check("timeout_busy_cycles", 32'(busy), 32'd15);
        check("timeout_bus_error", 32'(bus_error), 32'd1);
        check("timeout_done_stall", 32'(stall_mem), 32'd0);
        @(negedge clk);
        check("timeout_err_pulse", 32'(bus_error), 32'd0);
        check("timeout_wb_read_data", wb_read_data, 32'd0);
        check("timeout_wb_rd", 32'(wb_rd), 32'd3);
        drive_nop();
        #1;
        check("timeout_idle_stall", 32'(stall_mem), 32'd0);
        @(negedge clk);
        check("timeout_idle_req", 32'(dmem_bus.dmem_req), 32'd0);

        // Ack arriving in the last allowed BUSY cycle beats the timeout.
        drive(2'b01, 1'b0, 1'b1, 3'b000, 5'd8, 32'h31, 32'h0);
        busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!dmem_bus.dmem_req) break;
            busy++;
            if (busy == 15) begin
                dmem_bus.dmem_ack   = 1'b1;
                dmem_bus.dmem_rdata = 32'h00008000;
            end
        end
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        check("lastack_busy_cycles", 32'(busy), 32'd15);
        check("lastack_no_bus_error", 32'(bus_error), 32'd0);
        @(negedge clk);
        check("lastack_wb_read_data", wb_read_data, 32'hFFFFFF80);
        check("lastack_err_after", 32'(bus_error), 32'd0);
        drive_nop();
        @(negedge clk);

        // Reset during the second BUSY cycle, then a stray ack, then a clean access.
        drive(2'b01, 1'b0, 1'b1, 3'b010, 5'd2, 32'h50, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("abort_req_before", 32'(dmem_bus.dmem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_req", 32'(dmem_bus.dmem_req), 32'd0);
        check("abort_stall", 32'(stall_mem), 32'd0);
        check("abort_addr", dmem_bus.dmem_addr, 32'd0);
        check("abort_wb_reg_write", 32'(wb_reg_write), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive_nop();
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        check("stray_ack_req", 32'(dmem_bus.dmem_req), 32'd0);
        check("stray_ack_stall", 32'(stall_mem), 32'd0);
        check("stray_ack_bus_error", 32'(bus_error), 32'd0);
        check("stray_ack_wb_read_data", wb_read_data, 32'd0);
        apply(tbl[7]);
        drive_nop();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
